// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared types and timing defaults for the traffic light controller (TLC_ALL_RED_EN)
package tlc_pkg;

    localparam int DEF_MAIN_GREEN_MIN  = 10;
    localparam int DEF_YELLOW_TIME     = 3;
    localparam int DEF_SIDE_GREEN_TIME = 8;
    localparam int DEF_ALL_RED_TIME    = 2;

    // Lamp vector ordering is {red, yellow, green}.
    typedef logic [2:0] lamp_t;
    localparam lamp_t LAMP_RED    = 3'b100;
    localparam lamp_t LAMP_YELLOW = 3'b010;
    localparam lamp_t LAMP_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        ST_MAIN_GREEN  = 3'd0,
        ST_MAIN_YELLOW = 3'd1,
        ST_SIDE_GREEN  = 3'd2,
`ifdef TLC_ALL_RED_EN
        ST_SIDE_YELLOW = 3'd3,
        ST_ALL_RED_1   = 3'd4,
        ST_ALL_RED_2   = 3'd5
`else
        ST_SIDE_YELLOW = 3'd3
`endif
    } tlc_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/tlc_dwell_timer.sv
// rtl/tlc_dwell_timer.sv - saturating dwell counter, cleared on state entry
module tlc_dwell_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         done
);

    // limit is the terminal count (dwell - 1); the counter holds there.
    assign done = (count >= limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!done) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - two-road Moore traffic light controller (TLC_ALL_RED_EN adds all-red clearance)
module traffic_light_ctrl
    import tlc_pkg::*;
#(
    parameter int MAIN_GREEN_MIN  = DEF_MAIN_GREEN_MIN,
    parameter int YELLOW_TIME     = DEF_YELLOW_TIME,
    parameter int SIDE_GREEN_TIME = DEF_SIDE_GREEN_TIME,
    parameter int ALL_RED_TIME    = DEF_ALL_RED_TIME
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_Vs,
    output logic o_Main_red,
    output logic o_Main_yellow,
    output logic o_Main_green,
    output logic o_Side_red,
    output logic o_Side_yellow,
    output logic o_Side_green
);

    localparam int CNT_W = $clog2(max4(MAIN_GREEN_MIN, YELLOW_TIME,
                                       SIDE_GREEN_TIME, ALL_RED_TIME)) + 1;

    localparam logic [CNT_W-1:0] MG_LAST  = CNT_W'(MAIN_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] SG_LAST  = CNT_W'(SIDE_GREEN_TIME - 1);
`ifdef TLC_ALL_RED_EN
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED_TIME - 1);
`endif

    tlc_state_t       state;
    tlc_state_t       state_next;
    logic [CNT_W-1:0] dwell_count;
    logic [CNT_W-1:0] dwell_limit;
    logic             dwell_clear;
    logic             dwell_done;
    lamp_t            main_lamp;
    lamp_t            side_lamp;

    tlc_dwell_timer #(.W(CNT_W)) u_dwell_timer (
        .clk   (i_clk),
        .rst   (i_reset),
        .clear (dwell_clear),
        .limit (dwell_limit),
        .count (dwell_count),
        .done  (dwell_done)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_MAIN_GREEN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        dwell_limit = MG_LAST;
        main_lamp   = LAMP_RED;
        side_lamp   = LAMP_RED;
        case (state)
            ST_MAIN_GREEN: begin
                main_lamp = LAMP_GREEN;
                // The request is sampled live; nothing is remembered from earlier cycles.
                if (i_Vs && (dwell_count >= MG_LAST)) begin
                    state_next = ST_MAIN_YELLOW;
                end
            end
            ST_MAIN_YELLOW: begin
                main_lamp   = LAMP_YELLOW;
                dwell_limit = YEL_LAST;
                if (dwell_done) begin
`ifdef TLC_ALL_RED_EN
                    state_next = ST_ALL_RED_1;
`else
                    state_next = ST_SIDE_GREEN;
`endif
                end
            end
            ST_SIDE_GREEN: begin
                side_lamp   = LAMP_GREEN;
                dwell_limit = SG_LAST;
                if (dwell_done) begin
                    state_next = ST_SIDE_YELLOW;
                end
            end
            ST_SIDE_YELLOW: begin
                side_lamp   = LAMP_YELLOW;
                dwell_limit = YEL_LAST;
                if (dwell_done) begin
`ifdef TLC_ALL_RED_EN
                    state_next = ST_ALL_RED_2;
`else
                    state_next = ST_MAIN_GREEN;
`endif
                end
            end
`ifdef TLC_ALL_RED_EN
            ST_ALL_RED_1: begin
                dwell_limit = AR_LAST;
                if (dwell_done) begin
                    state_next = ST_SIDE_GREEN;
                end
            end
            ST_ALL_RED_2: begin
                dwell_limit = AR_LAST;
                if (dwell_done) begin
                    state_next = ST_MAIN_GREEN;
                end
            end
`endif
            default: begin
                state_next = ST_MAIN_GREEN;
            end
        endcase
        dwell_clear = (state_next != state);
    end

    assign {o_Main_red, o_Main_yellow, o_Main_green} = main_lamp;
    assign {o_Side_red, o_Side_yellow, o_Side_green} = side_lamp;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - randomized self-checking bench for traffic_light_ctrl (TLC_ALL_RED_EN aware)
module tb_traffic_light_ctrl;

    localparam int MGM = 10;
    localparam int YT  = 3;
    localparam int SGT = 8;
    localparam int ART = 2;

    // Lamp word ordering: {main r,y,g, side r,y,g}.
    localparam logic [5:0] L_MG = 6'b001_100;
    localparam logic [5:0] L_MY = 6'b010_100;
    localparam logic [5:0] L_SG = 6'b100_001;
    localparam logic [5:0] L_SY = 6'b100_010;
    localparam logic [5:0] L_AR = 6'b100_100;

    logic i_clk = 1'b0;
    logic i_reset;
    logic i_Vs;
    logic o_Main_red, o_Main_yellow, o_Main_green;
    logic o_Side_red, o_Side_yellow, o_Side_green;

    int n_checks = 0;
    int n_fail   = 0;

    int         ph_dur[6];
    logic [5:0] ph_lamp[6];
    int         n_ph;
    int         period;
    int         m_phase;
    int         m_elapsed;

    always #5 i_clk = ~i_clk;

    traffic_light_ctrl dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_Vs          (i_Vs),
        .o_Main_red    (o_Main_red),
        .o_Main_yellow (o_Main_yellow),
        .o_Main_green  (o_Main_green),
        .o_Side_red    (o_Side_red),
        .o_Side_yellow (o_Side_yellow),
        .o_Side_green  (o_Side_green)
    );

    function automatic logic [5:0] obs();
        return {o_Main_red, o_Main_yellow, o_Main_green, o_Side_red, o_Side_yellow, o_Side_green};
    endfunction

    task automatic build_model();
`ifdef TLC_ALL_RED_EN
        n_ph = 6;
        ph_lamp[0] = L_MG; ph_dur[0] = MGM;
        ph_lamp[1] = L_MY; ph_dur[1] = YT;
        ph_lamp[2] = L_AR; ph_dur[2] = ART;
        ph_lamp[3] = L_SG; ph_dur[3] = SGT;
        ph_lamp[4] = L_SY; ph_dur[4] = YT;
        ph_lamp[5] = L_AR; ph_dur[5] = ART;
`else
        n_ph = 4;
        ph_lamp[0] = L_MG; ph_dur[0] = MGM;
        ph_lamp[1] = L_MY; ph_dur[1] = YT;
        ph_lamp[2] = L_SG; ph_dur[2] = SGT;
        ph_lamp[3] = L_SY; ph_dur[3] = YT;
        ph_lamp[4] = L_MG; ph_dur[4] = 0;
        ph_lamp[5] = L_MG; ph_dur[5] = 0;
`endif
        period = 0;
        for (int i = 0; i < n_ph; i++) period += ph_dur[i];
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_elapsed = 0;
    endtask

    // Phase 0 is request-driven once its minimum has run; every other phase is a fixed dwell.
    task automatic model_step(input bit vs);
        bit advance;
        if (m_phase == 0) advance = vs && (m_elapsed + 1 >= ph_dur[0]);
        else              advance = (m_elapsed + 1 >= ph_dur[m_phase]);
        if (advance) begin
            m_phase   = (m_phase + 1) % n_ph;
            m_elapsed = 0;
        end else begin
            m_elapsed++;
        end
    endtask

    task automatic drive_cycle(input bit vs);
        i_Vs = vs;
        @(posedge i_clk);
        model_step(vs);
        @(negedge i_clk);
    endtask

    task automatic hold_reset(input int cycles);
        i_reset = 1'b1;
        model_reset();
        repeat (cycles) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_Vs    = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs() !== L_MG) $display("FAIL reset_immediate: lamps=%b expected=%b", obs(), L_MG);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        n_checks++;
        if (obs() !== L_MG) $display("FAIL reset_held: lamps=%b expected=%b", obs(), L_MG);
        i_reset = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            drive_cycle(1'b0);
            n_checks++;
            if (obs() !== L_MG) begin
                n_fail++;
                $display("FAIL idle_main_green cycle %0d: lamps=%b expected=%b", k, obs(), L_MG);
            end
        end
    endtask

    task automatic test_continuous();
        int first_y;
        int second_y;
        logic [5:0] prev;
        first_y  = -1;
        second_y = -1;
        hold_reset(2);
        prev = obs();
        for (int k = 1; k <= 2 * period + 12; k++) begin
            drive_cycle(1'b1);
            n_checks++;
            if (obs() !== ph_lamp[m_phase]) begin
                n_fail++;
                $display("FAIL continuous cycle %0d: lamps=%b expected=%b", k, obs(), ph_lamp[m_phase]);
            end
            if (obs() == L_MY && prev != L_MY) begin
                if (first_y < 0) first_y = k;
                else if (second_y < 0) second_y = k;
            end
            prev = obs();
        end
        n_checks++;
        if (first_y !== MGM) begin
            n_fail++;
            $display("FAIL first_yellow_edge: got=%0d expected=%0d", first_y, MGM);
        end
        n_checks++;
        if (second_y - first_y !== period) begin
            n_fail++;
            $display("FAIL cycle_period: got=%0d expected=%0d", second_y - first_y, period);
        end
    endtask

    task automatic test_lost_request();
        int others;
        others = 0;
        hold_reset(2);
        for (int k = 1; k <= 45; k++) begin
            drive_cycle((k >= 2) && (k <= 5));
            n_checks++;
            if (obs() !== ph_lamp[m_phase]) begin
                n_fail++;
                $display("FAIL lost_request cycle %0d: lamps=%b expected=%b", k, obs(), ph_lamp[m_phase]);
            end
            if (obs() != L_MG) others++;
        end
        n_checks++;
        if (others !== 0) begin
            n_fail++;
            $display("FAIL lost_request_stays_green: non_green_cycles=%0d expected=0", others);
        end
    endtask

    task automatic test_pulse();
        hold_reset(2);
        for (int k = 1; k <= 30; k++) drive_cycle(1'b0);
        drive_cycle(1'b1);
        n_checks++;
        if (obs() !== L_MY) begin
            n_fail++;
            $display("FAIL pulse_to_yellow: lamps=%b expected=%b", obs(), L_MY);
        end
        for (int k = 1; k <= period; k++) begin
            drive_cycle(1'b0);
            n_checks++;
            if (obs() !== ph_lamp[m_phase]) begin
                n_fail++;
                $display("FAIL pulse_sequence cycle %0d: lamps=%b expected=%b", k, obs(), ph_lamp[m_phase]);
            end
        end
        n_checks++;
        if (obs() !== L_MG) begin
            n_fail++;
            $display("FAIL pulse_returns_main_green: lamps=%b expected=%b", obs(), L_MG);
        end
    endtask

    task automatic test_async_reset();
        int found;
        int first_y;
        found   = 0;
        first_y = -1;
        hold_reset(2);
        for (int k = 0; k < 100 && found < 4; k++) begin
            drive_cycle(1'b1);
            if (obs() == L_SG) found++;
        end
        n_checks++;
        if (found < 4) begin
            n_fail++;
            $display("FAIL reach_side_green: side_green_cycles=%0d expected=4 within 100 cycles", found);
        end
        #2 i_reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (obs() !== L_MG) begin
            n_fail++;
            $display("FAIL async_reset_immediate: lamps=%b expected=%b", obs(), L_MG);
        end
        @(posedge i_clk);
        #2 i_reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            drive_cycle(1'b1);
            n_checks++;
            if (obs() !== ph_lamp[m_phase]) begin
                n_fail++;
                $display("FAIL after_async_reset cycle %0d: lamps=%b expected=%b", k, obs(), ph_lamp[m_phase]);
            end
            if (obs() == L_MY && first_y < 0) first_y = k;
        end
        n_checks++;
        if (first_y !== MGM) begin
            n_fail++;
            $display("FAIL async_reset_restart: yellow_edge=%0d expected=%0d", first_y, MGM);
        end
    endtask

    task automatic test_random();
        bit vs;
        int bias;
        hold_reset(1);
        for (int k = 1; k <= 600; k++) begin
            if ($urandom_range(0, 149) == 0) hold_reset(int'($urandom_range(1, 3)));
            bias = (k < 300) ? 3 : 12;
            vs   = ($urandom_range(0, bias) == 0);
            drive_cycle(vs);
            n_checks++;
            if (obs() !== ph_lamp[m_phase]) begin
                n_fail++;
                $display("FAIL random cycle %0d vs=%0b: lamps=%b expected=%b", k, vs, obs(), ph_lamp[m_phase]);
            end
            n_checks++;
            if (!(o_Main_red || o_Side_red)) begin
                n_fail++;
                $display("FAIL random_conflict cycle %0d: lamps=%b expected one road red", k, obs());
            end
        end
    endtask

    initial begin
        build_model();
        test_reset();
        test_continuous();
        test_lost_request();
        test_pulse();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
